// File: rtl/intersection_ctrl.sv
// Two-road junction phase scheduler: NS/EW green-yellow-allred cycle with pedestrian walk and emergency all-red.
// Lights are a pure decode of the state register; requests and emerg take effect on the next clock edge.
module intersection_ctrl #(
  parameter int TW        = 8,
  parameter int GREEN_T   = 20,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10,
  parameter int MIN_GREEN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    WALK  = 3'd6,
    EMERG = 3'd7
  } state_t;

  localparam logic [TW-1:0] LP_G_END = TW'(GREEN_T - 1);
  localparam logic [TW-1:0] LP_Y_END = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] LP_A_END = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] LP_W_END = TW'(WALK_T - 1);
  localparam logic [TW-1:0] LP_MIN   = TW'(MIN_GREEN - 1);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_t;
  logic          r_ped;
  logic          w_green_done;
  logic          w_enter_walk;

  // A green ends on emergency, on full expiry, or early once a walk is owed and the minimum is served.
  assign w_green_done = emerg || (r_t == LP_G_END) || (r_ped && (r_t >= LP_MIN));
  assign w_enter_walk = (w_next == WALK) && (r_state != WALK);

  always_comb begin
    w_next = r_state;
    case (r_state)
      NS_G:  if (w_green_done) w_next = NS_Y;
      NS_Y:  if (r_t == LP_Y_END) w_next = emerg ? EMERG : AR1;
      AR1: begin
        if (emerg)                  w_next = EMERG;
        else if (r_t == LP_A_END)   w_next = EW_G;
      end
      EW_G:  if (w_green_done) w_next = EW_Y;
      EW_Y:  if (r_t == LP_Y_END) w_next = emerg ? EMERG : AR2;
      AR2: begin
        if (emerg)                  w_next = EMERG;
        else if (r_t == LP_A_END)   w_next = r_ped ? WALK : NS_G;
      end
      WALK: begin
        if (emerg)                  w_next = EMERG;
        else if (r_t == LP_W_END)   w_next = NS_G;
      end
      EMERG: if (!emerg) w_next = AR2;
      default: w_next = AR2;
    endcase
  end

  // EMERG has no duration, so its timer is parked at 0 rather than left to wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= AR2;
      r_t     <= '0;
      r_ped   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || (r_state == EMERG)) r_t <= '0;
      else                                           r_t <= r_t + 1'b1;
      r_ped   <= ped_req || (r_ped && !w_enter_walk);
    end
  end

  always_comb begin
    ns_light = 3'b100;
    ew_light = 3'b100;
    walk     = 1'b0;
    case (r_state)
      NS_G:    ns_light = 3'b001;
      NS_Y:    ns_light = 3'b010;
      EW_G:    ew_light = 3'b001;
      EW_Y:    ew_light = 3'b010;
      WALK:    walk     = 1'b1;
      default: ;
    endcase
  end

  assign ped_pending = r_ped;
  assign phase       = r_state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl: phase durations, light decode, ped latch, emergency and async reset.
module tb_intersection_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ped_req;
  logic       emerg;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  intersection_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ped_req    (ped_req),
    .emerg      (emerg),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk       (walk),
    .ped_pending(ped_pending),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ns_exp(input logic [2:0] ph);
    case (ph)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] ew_exp(input logic [2:0] ph);
    case (ph)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Confirms we are in phase ph, checks the decode each cycle, then checks how many edges it lasts.
  task automatic measure(input logic [2:0] ph, input int len);
    int n;
    n = 0;
    check($sformatf("phase_entry_%0d", ph), phase, ph);
    do begin
      check($sformatf("ns_light_ph%0d", ph), ns_light, ns_exp(ph));
      check($sformatf("ew_light_ph%0d", ph), ew_light, ew_exp(ph));
      check($sformatf("walk_ph%0d", ph), walk, (ph == 3'd6) ? 1 : 0);
      step();
      n++;
    end while ((phase == ph) && (n < 300));
    check($sformatf("duration_ph%0d", ph), n, len);
  endtask

  initial begin
    rst_n   = 1'b0;
    ped_req = 1'b0;
    emerg   = 1'b0;
    #12;
    check("rst_phase", phase, 5);
    check("rst_ns", ns_light, 3'b100);
    check("rst_ew", ew_light, 3'b100);
    check("rst_walk", walk, 0);
    check("rst_ped", ped_pending, 0);
    step();
    rst_n = 1'b1;

    // Idle round after reset
    measure(3'd5, 2);
    measure(3'd0, 20);
    measure(3'd1, 4);
    measure(3'd2, 2);
    measure(3'd3, 20);
    measure(3'd4, 4);
    measure(3'd5, 2);

    // Pulse at NS_G t=1: both greens truncated to 5, then WALK
    check("s2_start", phase, 0);
    step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("s2_ped_latched", ped_pending, 1);
    measure(3'd0, 3);
    measure(3'd1, 4);
    measure(3'd2, 2);
    measure(3'd3, 5);
    measure(3'd4, 4);
    check("s2_ped_before_walk", ped_pending, 1);
    measure(3'd5, 2);
    check("s2_ped_cleared", ped_pending, 0);
    measure(3'd6, 10);

    // Request pending by NS_G t=10: green lasts 11 cycles
    for (int i = 0; i < 9; i++) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    measure(3'd0, 1);
    measure(3'd1, 4);
    measure(3'd2, 2);
    measure(3'd3, 5);
    measure(3'd4, 4);
    measure(3'd5, 2);
    measure(3'd6, 10);

    // Emergency at EW_G t=3
    measure(3'd0, 20);
    measure(3'd1, 4);
    measure(3'd2, 2);
    for (int i = 0; i < 3; i++) step();
    emerg = 1'b1;
    step();
    measure(3'd4, 4);
    for (int i = 0; i < 10; i++) begin
      check("emerg_hold", phase, 7);
      check("emerg_ns", ns_light, 3'b100);
      check("emerg_ew", ew_light, 3'b100);
      step();
    end
    check("emerg_last", phase, 7);
    emerg = 1'b0;
    step();
    measure(3'd5, 2);

    // Request held across the WALK entry edge re-arms for the next round
    ped_req = 1'b1;
    measure(3'd0, 5);
    measure(3'd1, 4);
    measure(3'd2, 2);
    measure(3'd3, 5);
    measure(3'd4, 4);
    measure(3'd5, 2);
    check("s5_walk1", phase, 6);
    check("s5_ped_held", ped_pending, 1);
    step();
    ped_req = 1'b0;
    check("s5_ped_still", ped_pending, 1);
    measure(3'd6, 9);
    measure(3'd0, 5);
    measure(3'd1, 4);
    measure(3'd2, 2);
    measure(3'd3, 5);
    measure(3'd4, 4);
    measure(3'd5, 2);
    check("s5_ped_cleared", ped_pending, 0);
    measure(3'd6, 10);

    // Asynchronous reset at EW_Y t=2
    measure(3'd0, 20);
    measure(3'd1, 4);
    measure(3'd2, 2);
    measure(3'd3, 20);
    check("s6_in_ew_y", phase, 4);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    step();
    check("s6_ped_set", ped_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_arst_phase", phase, 5);
    check("s6_arst_ns", ns_light, 3'b100);
    check("s6_arst_ew", ew_light, 3'b100);
    check("s6_arst_ped", ped_pending, 0);
    check("s6_arst_walk", walk, 0);
    step();
    step();
    rst_n = 1'b1;
    measure(3'd5, 2);
    measure(3'd0, 20);
    measure(3'd1, 4);
    check("s6_end", phase, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
